// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and default sizes for the main memory interface
// Purpose: access-sequencer state encoding and the default memory geometry.
// Contents: mem_state_e (IDLE, WAIT, ACCESS, DONE), DATA_W_DEF, ADDR_W_DEF,
//           MEM_DEPTH_DEF, WAIT_STATES_DEF.
package cpu_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int ADDR_W_DEF      = 9;
    localparam int MEM_DEPTH_DEF   = 512;
    localparam int WAIT_STATES_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } mem_state_e;

endpackage

// File: rtl/memory_interface_ram_sp.sv
// rtl/memory_interface_ram_sp.sv - single-port synchronous RAM for the main memory
// Purpose: word array with a registered read port; contents are never reset.
// Ports:
//   clock  in   rising-edge clock
//   we     in   write enable, commits din at addr on the rising edge
//   addr   in   ADDR_W word index
//   din    in   DATA_W write data
//   dout   out  DATA_W read data, one cycle after addr is presented
module ram_sp
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = MEM_DEPTH_DEF
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout <= mem_q[addr];
    end

endmodule

// File: rtl/memory_interface.sv
// rtl/memory_interface.sv - word-addressed main memory with wait-state access sequencer
// Purpose: accepts Read/Write strobe rising edges, runs IDLE->WAIT->ACCESS->DONE,
//          returns read data on Mdatain and pulses mem_done on completion.
// Optional feature: MEM_RANGE_CHECK_EN adds mem_err and treats mar_in >= MEM_DEPTH
//          as an error (write suppressed, read returns 0).
// Ports:
//   clock     in   system clock, rising edge
//   clear     in   asynchronous active-high reset
//   mar_in    in   32-bit address from MAR (index = mar_in mod 2**ADDR_W)
//   mdr_in    in   write data from MDR
//   Read      in   read request level, accepted on its rising edge in IDLE
//   Write     in   write request level, accepted on its rising edge in IDLE
//   Mdatain   out  last read data
//   mem_busy  out  high from the cycle after acceptance through DONE
//   mem_done  out  one-cycle completion pulse
//   mem_err   out  (MEM_RANGE_CHECK_EN only) pulses with mem_done on a bad address
module memory_interface
    import cpu_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter int WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [31:0]       mar_in,
    input  logic [DATA_W-1:0] mdr_in,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mem_busy,
    output logic              mem_done
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic              mem_err
`endif
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    mem_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              read_q, write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              op_wr_q;
    logic              err_q;
    logic [DATA_W-1:0] mdatain_q;

    logic              req_rd, req_wr, req, accept;
    logic              addr_err;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;
    logic              rd_done;
    logic [DATA_W-1:0] rd_data;

    // Address bits above ADDR_W are deliberately ignored so addresses alias.
    logic              unused_hi;
    assign unused_hi = ^mar_in[31:ADDR_W];

    assign req_rd = Read & ~read_q;
    assign req_wr = Write & ~write_q;
    assign req    = req_rd | req_wr;
    assign accept = (state_q == ST_IDLE) & req;

`ifdef MEM_RANGE_CHECK_EN
    assign addr_err = (mar_in >= 32'(MEM_DEPTH));
`else
    assign addr_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The array only commits in ACCESS, so a clear during WAIT aborts the write.
    assign ram_we = (state_q == ST_ACCESS) & op_wr_q & ~err_q;

    ram_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (addr_q),
        .din   (wdata_q),
        .dout  (ram_dout)
    );

    // The RAM output is valid in DONE, so forward it straight to Mdatain in that
    // cycle and capture it for the cycles that follow.
    assign rd_done = (state_q == ST_DONE) & ~op_wr_q;
    assign rd_data = err_q ? '0 : ram_dout;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            op_wr_q   <= 1'b0;
            err_q     <= 1'b0;
            mdatain_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            read_q  <= Read;
            write_q <= Write;
            if (accept) begin
                addr_q  <= mar_in[ADDR_W-1:0];
                wdata_q <= mdr_in;
                op_wr_q <= req_wr;  // write wins over a simultaneous read edge
                err_q   <= addr_err;
            end
            if (rd_done) begin
                mdatain_q <= rd_data;
            end
        end
    end

    assign Mdatain  = rd_done ? rd_data : mdatain_q;
    assign mem_busy = (state_q != ST_IDLE);
    assign mem_done = (state_q == ST_DONE);

`ifdef MEM_RANGE_CHECK_EN
    assign mem_err = (state_q == ST_DONE) & err_q;
`endif

endmodule

// File: tb/tb_memory_interface.sv
// tb/tb_memory_interface.sv - randomized self-checking bench for memory_interface
module tb_memory_interface;

    localparam int N     = 3;
    localparam int WORDS = 512;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] mar_in, mdr_in;
    logic        Read, Write;
    logic [31:0] mdat [N];
    logic        busy [N];
    logic        done [N];
`ifdef MEM_RANGE_CHECK_EN
    logic        err  [N];
`endif

    always #5 clock = ~clock;

    memory_interface #(.WAIT_STATES(0)) u_ws0 (
        .clock(clock), .clear(clear), .mar_in(mar_in), .mdr_in(mdr_in),
        .Read(Read), .Write(Write), .Mdatain(mdat[0]), .mem_busy(busy[0]),
        .mem_done(done[0])
`ifdef MEM_RANGE_CHECK_EN
        , .mem_err(err[0])
`endif
    );

    memory_interface #(.WAIT_STATES(1)) u_ws1 (
        .clock(clock), .clear(clear), .mar_in(mar_in), .mdr_in(mdr_in),
        .Read(Read), .Write(Write), .Mdatain(mdat[1]), .mem_busy(busy[1]),
        .mem_done(done[1])
`ifdef MEM_RANGE_CHECK_EN
        , .mem_err(err[1])
`endif
    );

    memory_interface #(.WAIT_STATES(3)) u_ws3 (
        .clock(clock), .clear(clear), .mar_in(mar_in), .mdr_in(mdr_in),
        .Read(Read), .Write(Write), .Mdatain(mdat[2]), .mem_busy(busy[2]),
        .mem_done(done[2])
`ifdef MEM_RANGE_CHECK_EN
        , .mem_err(err[2])
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m   [WORDS];
    bit          written [WORDS];
    logic [31:0] last_rd;

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return (a >= 32'd512);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("%s_mdat%0d", tag, i), mdat[i], 32'd0);
            check_eq($sformatf("%s_busy%0d", tag, i), {31'd0, busy[i]}, 32'd0);
            check_eq($sformatf("%s_done%0d", tag, i), {31'd0, done[i]}, 32'd0);
`ifdef MEM_RANGE_CHECK_EN
            check_eq($sformatf("%s_err%0d", tag, i), {31'd0, err[i]}, 32'd0);
`endif
        end
    endtask

    // One access from strobe edge to idle. hold: cycles the strobes stay high.
    // re_at (>0): Read is pulsed again at that cycle, while every instance is busy.
    task automatic do_op(input string tag, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input int hold, input int re_at);
        bit          op_wr;
        bit          bad;
        int          idx;
        int          lat;
        logic [31:0] prev;
        logic [31:0] exp_rd;
        logic [31:0] exp_m;
        op_wr  = wr;
        bad    = addr_bad(addr);
        idx    = int'(addr % 32'd512);
        prev   = last_rd;
        exp_rd = prev;
        if (op_wr) begin
            if (!bad) begin
                mem_m[idx]   = data;
                written[idx] = 1'b1;
            end
        end else begin
            exp_rd = bad ? 32'd0 : mem_m[idx];
        end
        @(negedge clock);
        mar_in = addr;
        mdr_in = data;
        Read   = rd;
        Write  = wr;
        for (int c = 1; c <= hold + 8; c++) begin
            @(negedge clock);
            if (c == hold) begin
                Read  = 1'b0;
                Write = 1'b0;
            end
            if (re_at > 0 && c == re_at)     Read = 1'b1;
            if (re_at > 0 && c == re_at + 1) Read = 1'b0;
            for (int i = 0; i < N; i++) begin
                lat   = ws_of(i) + 2;
                exp_m = (!op_wr && c >= lat) ? exp_rd : prev;
                check_eq($sformatf("%s_busy%0d_c%0d", tag, i, c), {31'd0, busy[i]}, (c <= lat) ? 32'd1 : 32'd0);
                check_eq($sformatf("%s_done%0d_c%0d", tag, i, c), {31'd0, done[i]}, (c == lat) ? 32'd1 : 32'd0);
                check_eq($sformatf("%s_mdat%0d_c%0d", tag, i, c), mdat[i], exp_m);
`ifdef MEM_RANGE_CHECK_EN
                check_eq($sformatf("%s_err%0d_c%0d", tag, i, c), {31'd0, err[i]}, (c == lat && bad) ? 32'd1 : 32'd0);
`endif
            end
        end
        last_rd = exp_rd;
    endtask

    initial begin
        logic [31:0] a, d;
        bit          is_rd;
        clear   = 1'b1;
        Read    = 1'b0;
        Write   = 1'b0;
        mar_in  = 32'd0;
        mdr_in  = 32'd0;
        last_rd = 32'd0;
        for (int i = 0; i < WORDS; i++) begin
            mem_m[i]   = 32'd0;
            written[i] = 1'b0;
        end
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        clear = 1'b0;

        do_op("wr_dead", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1, 0);
        do_op("rd_dead", 1'b1, 1'b0, 32'h10, 32'h0, 1, 0);
        do_op("wr_zero", 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 1, 0);
        do_op("rd_zero", 1'b1, 1'b0, 32'h0, 32'h0, 1, 0);
        do_op("rd_held", 1'b1, 1'b0, 32'h10, 32'h0, 20, 0);
        do_op("rw_both", 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 1, 0);
        do_op("rd_both", 1'b1, 1'b0, 32'h20, 32'h0, 1, 0);

        do_op("wr_1234", 1'b0, 1'b1, 32'h5, 32'h1234, 1, 0);
        @(negedge clock);
        mar_in = 32'h5;
        mdr_in = 32'h9999;
        Write  = 1'b1;
        @(negedge clock);
        clear = 1'b1;
        Write = 1'b0;
        #1;
        check_idle_outputs("clr_async");
        @(negedge clock);
        check_idle_outputs("clr_held");
        clear   = 1'b0;
        last_rd = 32'd0;
        do_op("rd_after_clr", 1'b1, 1'b0, 32'h5, 32'h0, 1, 0);

        do_op("rd_busy_edge", 1'b1, 1'b0, 32'h10, 32'h0, 1, 2);

`ifdef MEM_RANGE_CHECK_EN
        do_op("wr_88", 1'b0, 1'b1, 32'd88, 32'h88888888, 1, 0);
        do_op("wr_600", 1'b0, 1'b1, 32'd600, 32'h00000600, 1, 0);
        do_op("rd_600", 1'b1, 1'b0, 32'd600, 32'h0, 1, 0);
        do_op("rd_88", 1'b1, 1'b0, 32'd88, 32'h0, 1, 0);
`else
        do_op("wr_205", 1'b0, 1'b1, 32'h205, 32'hCAFE0205, 1, 0);
        do_op("rd_005", 1'b1, 1'b0, 32'h005, 32'h0, 1, 0);
`endif

        for (int n = 0; n < 40; n++) begin
`ifdef MEM_RANGE_CHECK_EN
            a = 32'($urandom_range(0, 1023));
`else
            a = $urandom;
`endif
            d     = $urandom;
            is_rd = ($urandom_range(0, 1) == 1);
            if (is_rd && !addr_bad(a) && !written[int'(a % 32'd512)]) is_rd = 1'b0;
            do_op($sformatf("rand%0d", n), is_rd, !is_rd, a, d, $urandom_range(1, 3), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
